mprj_ram_arbiter: RTL and testbench

MPRJ_RAM_ARBITER -- requirements
Module: mprj_ram_arbiter

---
 rtl/mprj_ram_arbiter_if.sv | 46 ++++
 rtl/mprj_ram_arbiter.sv | 108 ++++++++++
 tb/tb_mprj_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mprj_ram_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the mprjram arbiter and the single-port BRAM.
interface mprj_ram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              a_req;
  logic              a_we;
  logic [3:0]        a_sel;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic              a_ack;
  logic [31:0]       a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [31:0]       b_wdata;
  logic              b_ack;
  logic [31:0]       b_rdata;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic              busy;
  logic [1:0]        grant;

  modport slave (
    input  a_req, a_we, a_sel, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output busy, grant
  );

  modport master (
    output a_req, a_we, a_sel, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  busy, grant
  );
endinterface

// File: rtl/mprj_ram_arbiter.sv
// Two-port (CPU A / DMA B) round-robin arbiter in front of a single-port BRAM with fixed read latency.
//   state  | meaning
//   IDLE   | no owner; pick a requester (just-acked port masked for one cycle)
//   ACCESS | one-cycle BRAM enable from the latched request
//   WAIT   | read latency countdown; capture ram_rdata at terminal count
//   ACK    | one-cycle ack to the owner; round-robin pointer updated
module mprj_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DELAY  = 10
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n,
  mprj_ram_arbiter_if.slave    bus
);
  localparam int CNT_W = $clog2(DELAY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_b;
  logic              r_last_b;
  logic              r_after_ack;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_a_rdata;
  logic [31:0]       r_b_rdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_req_a;
  logic              w_req_b;
  logic              w_pick_b;
  logic              w_grant;

  always_comb begin
    w_next   = r_state;
    // the port acked last cycle still has stb high for one more cycle
    w_req_a  = bus.a_req && !(r_after_ack && !r_owner_b);
    w_req_b  = bus.b_req && !(r_after_ack && r_owner_b);
    w_grant  = w_req_a || w_req_b;
    w_pick_b = w_req_b && (!w_req_a || !r_last_b);
    case (r_state)
      S_IDLE:   if (w_grant) w_next = S_ACCESS;
      S_ACCESS: w_next = r_we ? S_ACK : S_WAIT;
      S_WAIT:   if (r_cnt == '0) w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state     <= S_IDLE;
      r_owner_b   <= 1'b0;
      r_last_b    <= 1'b1;
      r_after_ack <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_a_rdata   <= 32'h0;
      r_b_rdata   <= 32'h0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_next;
      r_after_ack <= (r_state == S_ACK);
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner_b <= w_pick_b;
            r_we      <= w_pick_b ? bus.b_we    : bus.a_we;
            r_sel     <= w_pick_b ? 4'hF        : bus.a_sel;
            r_addr    <= w_pick_b ? bus.b_addr  : bus.a_addr;
            r_wdata   <= w_pick_b ? bus.b_wdata : bus.a_wdata;
          end
        end
        S_ACCESS: begin
          if (!r_we) r_cnt <= CNT_W'(DELAY - 1);
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_owner_b) r_b_rdata <= bus.ram_rdata;
            else           r_a_rdata <= bus.ram_rdata;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          r_last_b <= r_owner_b;
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_en    = (r_state == S_ACCESS);
  assign bus.ram_we    = (r_state == S_ACCESS && r_we) ? r_sel : 4'h0;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.a_ack     = (r_state == S_ACK) && !r_owner_b;
  assign bus.b_ack     = (r_state == S_ACK) && r_owner_b;
  assign bus.a_rdata   = r_a_rdata;
  assign bus.b_rdata   = r_b_rdata;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.grant     = (r_state == S_IDLE) ? 2'b00 : (r_owner_b ? 2'b10 : 2'b01);
endmodule

// File: tb/tb_mprj_ram_arbiter.sv
// Directed bench for mprj_ram_arbiter: BRAM model with DELAY-cycle read pipe, CPU/DMA request tasks.
module tb_mprj_ram_arbiter;
  localparam int ADDR_W = 12;
  localparam int DELAY  = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  mprj_ram_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  mprj_ram_arbiter #(.ADDR_W(ADDR_W), .DELAY(DELAY)) u_dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: data is valid on ram_rdata only in the single cycle DELAY after the enable
  logic [31:0] mem  [0:(1<<ADDR_W)-1];
  logic [31:0] pipe [0:DELAY-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int k = 0; k < 4; k++)
        if (bus.ram_we[k]) mem[bus.ram_addr][8*k +: 8] <= bus.ram_wdata[8*k +: 8];
      pipe[0] <= mem[bus.ram_addr];
    end else begin
      pipe[0] <= 32'hBAD0_0000 ^ cyc;
    end
    for (int k = 1; k < DELAY; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.ram_rdata = pipe[DELAY-1];

  int         en_cnt = 0, ack_wide = 0, bad_grant = 0, bad_en = 0, b_ack_cnt = 0;
  logic       prev_a = 1'b0, prev_b = 1'b0;
  logic [3:0] last_we = 4'h0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [1:0] gq [$];
  always @(negedge clk) begin
    if (bus.ram_en) begin
      en_cnt    <= en_cnt + 1;
      last_we   <= bus.ram_we;
      last_addr <= bus.ram_addr;
      gq.push_back(bus.grant);
    end
    if ((bus.a_ack && prev_a) || (bus.b_ack && prev_b)) ack_wide <= ack_wide + 1;
    if (bus.grant == 2'b11) bad_grant <= bad_grant + 1;
    if (!bus.busy && (bus.ram_en || bus.ram_we != 4'h0)) bad_en <= bad_en + 1;
    if (bus.b_ack) b_ack_cnt <= b_ack_cnt + 1;
    prev_a <= bus.a_ack;
    prev_b <= bus.b_ack;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; lat is measured in cycles from the cycle the request is first presented.
  task automatic a_txn(input logic we, input logic [3:0] sel, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd);
    int t0;
    bit got;
    t0 = cyc; got = 0; lat = -1; rd = 32'h0;
    bus.a_req = 1'b1; bus.a_we = we; bus.a_sel = sel; bus.a_addr = addr; bus.a_wdata = wd;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.grant == 2'b01) begin
        bus.a_sel = ~sel; bus.a_addr = ~addr; bus.a_wdata = ~wd;
      end
      if (bus.a_ack) begin
        got = 1; lat = cyc - t0; rd = bus.a_rdata;
      end
    end
    bus.a_req = 1'b0;
    check("a_done", 32'(got), 32'd1);
  endtask

  task automatic b_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd);
    int t0;
    bit got;
    t0 = cyc; got = 0; lat = -1; rd = 32'h0;
    bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.grant == 2'b10) begin
        bus.b_addr = ~addr; bus.b_wdata = ~wd;
      end
      if (bus.b_ack) begin
        got = 1; lat = cyc - t0; rd = bus.b_rdata;
      end
    end
    bus.b_req = 1'b0;
    check("b_done", 32'(got), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_grant"},  32'(bus.grant),  32'd0);
    check({tag, "_ram_en"}, 32'(bus.ram_en), 32'd0);
    check({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
    check({tag, "_acks"},   32'({bus.a_ack, bus.b_ack}), 32'd0);
    check({tag, "_a_rdata"}, bus.a_rdata, 32'd0);
    check({tag, "_b_rdata"}, bus.b_rdata, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_a, lat_b, e0, q0, bc0;
    logic [31:0] rd_a, rd_b;
    logic [1:0] exp_g [5];
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    rst_n = 1'b0;
    bus.a_req = 0; bus.a_we = 0; bus.a_sel = 4'h0; bus.a_addr = '0; bus.a_wdata = 32'h0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full write then read of the same word
    a_txn(1'b1, 4'hF, 12'h010, 32'hDEADBEEF, lat_a, rd_a);
    check("wr_lat", 32'(lat_a), 32'd2);
    check("wr_ram_we", 32'(last_we), 32'hF);
    check("wr_ram_addr", 32'(last_addr), 32'h010);
    repeat (2) @(negedge clk);
    a_txn(1'b0, 4'hF, 12'h010, 32'h0, lat_a, rd_a);
    check("rd_lat", 32'(lat_a), 32'd12);
    check("rd_data", rd_a, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    b_txn(1'b1, 12'h020, 32'hCAFEF00D, lat_b, rd_b);
    check("b_wr_lat", 32'(lat_b), 32'd2);
    check("b_wr_ram_we", 32'(last_we), 32'hF);

    // simultaneous reads straight after reset: A first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    e0 = en_cnt;
    fork
      a_txn(1'b0, 4'hF, 12'h010, 32'h0, lat_a, rd_a);
      b_txn(1'b0, 12'h020, 32'h0, lat_b, rd_b);
    join
    check("both_a_lat", 32'(lat_a), 32'd12);
    check("both_b_lat", 32'(lat_b), 32'd25);
    check("both_a_data", rd_a, 32'hDEADBEEF);
    check("both_b_data", rd_b, 32'hCAFEF00D);
    check("both_en_pulses", 32'(en_cnt - e0), 32'd2);
    check("both_a_hold", bus.a_rdata, 32'hDEADBEEF);

    // B streams writes while A keeps requesting reads: grants alternate
    repeat (2) @(negedge clk);
    q0 = gq.size();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int l;
          logic [31:0] r;
          b_txn(1'b1, ADDR_W'(12'h030 + i), 32'h1000 + i, l, r);
        end
      end
      begin
        @(negedge clk);
        a_txn(1'b0, 4'hF, 12'h010, 32'h0, lat_a, rd_a);
        check("alt_rd0", rd_a, 32'hDEADBEEF);
        a_txn(1'b0, 4'hF, 12'h020, 32'h0, lat_a, rd_a);
        check("alt_rd1", rd_a, 32'hCAFEF00D);
      end
    join
    check("alt_count", 32'(gq.size() - q0), 32'd5);
    for (int k = 0; k < 5; k++)
      if (q0 + k < gq.size()) check("alt_grant", 32'(gq[q0+k]), 32'(exp_g[k]));
    for (int i = 0; i < 3; i++)
      check("alt_mem", mem[12'h030 + i], 32'h1000 + i);
    check("alt_b_rdata_hold", bus.b_rdata, 32'hCAFEF00D);

    // byte-lane write
    repeat (2) @(negedge clk);
    a_txn(1'b1, 4'hF, 12'h040, 32'h11223344, lat_a, rd_a);
    repeat (2) @(negedge clk);
    a_txn(1'b1, 4'b0010, 12'h040, 32'h0000AB00, lat_a, rd_a);
    check("byte_lat", 32'(lat_a), 32'd2);
    check("byte_ram_we", 32'(last_we), 32'h2);
    check("byte_rdata_hold", bus.a_rdata, 32'hCAFEF00D);
    repeat (2) @(negedge clk);
    a_txn(1'b0, 4'hF, 12'h040, 32'h0, lat_a, rd_a);
    check("byte_rd_lat", 32'(lat_a), 32'd12);
    check("byte_rd_data", rd_a, 32'h1122AB44);

    // last owner was A: a simultaneous pair goes to B first
    repeat (2) @(negedge clk);
    fork
      a_txn(1'b1, 4'hF, 12'h050, 32'h55555555, lat_a, rd_a);
      b_txn(1'b1, 12'h051, 32'h66666666, lat_b, rd_b);
    join
    check("rr_b_lat", 32'(lat_b), 32'd2);
    check("rr_a_lat", 32'(lat_a), 32'd5);

    // reset in the middle of a B read
    repeat (2) @(negedge clk);
    bc0 = b_ack_cnt;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 12'h020; bus.b_wdata = 32'h0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", 32'(bus.grant), 32'h2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    bus.b_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (DELAY + 4) @(negedge clk);
    check("abort_no_back", 32'(b_ack_cnt - bc0), 32'd0);
    a_txn(1'b0, 4'hF, 12'h010, 32'h0, lat_a, rd_a);
    check("abort_rd_lat", 32'(lat_a), 32'd12);
    check("abort_rd_data", rd_a, 32'hDEADBEEF);

    // FIR-style stream: DMA fills, CPU reads back
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) b_txn(1'b1, ADDR_W'(12'h100 + i), 32'(i), lat_b, rd_b);
    for (int i = 0; i < 64; i++) begin
      a_txn(1'b0, 4'hF, ADDR_W'(12'h100 + i), 32'h0, lat_a, rd_a);
      check("fir_rd", rd_a, 32'(i));
    end
    @(negedge clk);
    check("ack_width", 32'(ack_wide), 32'd0);
    check("grant_11", 32'(bad_grant), 32'd0);
    check("ram_en_idle", 32'(bad_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
